contrast_stretch_apply: RTL and testbench

Second pass of the contrast-stretching pipeline. It starts on the min/max result from the min/max finder. It reads every pixel of the source frame RAM and remaps it linearly so that [min,max] maps onto [0, 2^DATA_WIDTH-1]. It writes the result to the destination frame RAM. A scale factor is computed once per frame with a sequential divider, then the block streams one pixel per clock through a 3-stage pipeline.

---
 rtl/contrast_stretch_apply.sv | 165 ++++++++++++++++
 tb/tb_contrast_stretch_apply.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/contrast_stretch_apply.sv
// Contrast stretch, second pass: per-frame scale by restoring divide,
// then a one-pixel-per-clock remap from the source RAM into the destination RAM.
module contrast_stretch_apply #(
  parameter int DATA_WIDTH = 8,
  parameter int RAM_DEPTH  = 76800,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int FRAC_BITS  = 8
) (
  input  logic                  clk_i_stretch,
  input  logic                  rst_i_stretch,
  input  logic                  start_i_stretch,
  input  logic [DATA_WIDTH-1:0] min_i_stretch,
  input  logic [DATA_WIDTH-1:0] max_i_stretch,
  output logic                  rd_en_o_stretch,
  output logic [ADDR_WIDTH-1:0] rd_addr_o_stretch,
  input  logic [DATA_WIDTH-1:0] rd_data_i_stretch,
  output logic                  wr_en_o_stretch,
  output logic [ADDR_WIDTH-1:0] wr_addr_o_stretch,
  output logic [DATA_WIDTH-1:0] wr_data_o_stretch,
  output logic                  last_o_stretch,
  output logic                  busy_o_stretch,
  output logic                  done_o_stretch
);

  localparam int SCALE_W = DATA_WIDTH + FRAC_BITS;
  localparam int PROD_W  = DATA_WIDTH + SCALE_W;
  localparam int RES_W   = PROD_W - FRAC_BITS + 1;
  localparam int CNT_W   = $clog2(SCALE_W + 1);

  localparam logic [SCALE_W-1:0] NUMER =
    {{DATA_WIDTH{1'b1}}, {FRAC_BITS{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;
  localparam logic [PROD_W:0] ROUND =
    (PROD_W + 1)'(1) << (FRAC_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, DIV, STREAM, FLUSH, S_END
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] min_q;
  logic [DATA_WIDTH-1:0] range_q;
  logic                  bypass_q;
  logic [SCALE_W-1:0]    num_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [SCALE_W-1:0]    quo_q;
  logic [CNT_W-1:0]      cnt_q;

  logic [DATA_WIDTH:0]   rem_sh;
  logic                  q_bit;

  assign rem_sh = {rem_q, num_q[SCALE_W-1]};
  assign q_bit  = rem_sh >= {1'b0, range_q};

  assign busy_o_stretch = state != IDLE;

  always_ff @(posedge clk_i_stretch or posedge rst_i_stretch) begin
    if (rst_i_stretch) begin
      state             <= IDLE;
      min_q             <= '0;
      range_q           <= '0;
      bypass_q          <= 1'b0;
      num_q             <= '0;
      rem_q             <= '0;
      quo_q             <= '0;
      cnt_q             <= '0;
      rd_en_o_stretch   <= 1'b0;
      rd_addr_o_stretch <= '0;
      done_o_stretch    <= 1'b0;
    end else begin
      done_o_stretch <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i_stretch) begin
            min_q    <= min_i_stretch;
            range_q  <= max_i_stretch - min_i_stretch;
            bypass_q <= max_i_stretch <= min_i_stretch;
            num_q    <= NUMER;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            state    <= DIV;
          end
        end
        DIV: begin
          num_q <= num_q << 1;
          rem_q <= DATA_WIDTH'(q_bit ? rem_sh - {1'b0, range_q}
                                     : rem_sh);
          quo_q <= {quo_q[SCALE_W-2:0], q_bit};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SCALE_W - 1)) begin
            rd_en_o_stretch   <= 1'b1;
            rd_addr_o_stretch <= '0;
            state             <= STREAM;
          end
        end
        STREAM: begin
          if (rd_addr_o_stretch == LAST_ADDR) begin
            rd_en_o_stretch <= 1'b0;
            state           <= FLUSH;
          end else begin
            rd_addr_o_stretch <= rd_addr_o_stretch + ADDR_WIDTH'(1);
          end
        end
        FLUSH: begin
          if (last_o_stretch) begin
            done_o_stretch <= 1'b1;
            state          <= S_END;
          end
        end
        S_END: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // v0: read issued last cycle, so rd_data is valid now
  logic                  v0;
  logic [ADDR_WIDTH-1:0] a0;
  logic                  p_v;
  logic [ADDR_WIDTH-1:0] p_addr;
  logic [DATA_WIDTH-1:0] p_raw;
  logic [PROD_W-1:0]     p_prod;
  logic [DATA_WIDTH-1:0] diff;
  logic [RES_W-1:0]      res;

  assign diff = (rd_data_i_stretch < min_q) ? '0
              : rd_data_i_stretch - min_q;
  assign res  = RES_W'(({1'b0, p_prod} + ROUND) >> FRAC_BITS);

  always_ff @(posedge clk_i_stretch or posedge rst_i_stretch) begin
    if (rst_i_stretch) begin
      v0                <= 1'b0;
      a0                <= '0;
      p_v               <= 1'b0;
      p_addr            <= '0;
      p_raw             <= '0;
      p_prod            <= '0;
      wr_en_o_stretch   <= 1'b0;
      wr_addr_o_stretch <= '0;
      wr_data_o_stretch <= '0;
      last_o_stretch    <= 1'b0;
    end else begin
      v0     <= rd_en_o_stretch;
      a0     <= rd_addr_o_stretch;
      p_v    <= v0;
      p_addr <= a0;
      p_raw  <= rd_data_i_stretch;
      p_prod <= PROD_W'(diff) * PROD_W'(quo_q);
      wr_en_o_stretch   <= p_v;
      wr_addr_o_stretch <= p_addr;
      last_o_stretch    <= p_v && (p_addr == LAST_ADDR);
      if (bypass_q)
        wr_data_o_stretch <= p_raw;
      else if (res > RES_W'(PIX_MAX))
        wr_data_o_stretch <= PIX_MAX;
      else
        wr_data_o_stretch <= res[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_contrast_stretch_apply.sv
// Directed bench for contrast_stretch_apply at RAM_DEPTH=16:
// hand-computed pixel results, cycle-exact frame timing and reset abort.
module tb_contrast_stretch_apply;

  localparam int DW = 8;
  localparam int D  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] min_v = '0;
  logic [DW-1:0] max_v = '0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          last;
  logic          busy;
  logic          done;

  contrast_stretch_apply #(
    .DATA_WIDTH(DW), .RAM_DEPTH(D), .ADDR_WIDTH(AW), .FRAC_BITS(8)
  ) dut (
    .clk_i_stretch    (clk),
    .rst_i_stretch    (rst),
    .start_i_stretch  (start),
    .min_i_stretch    (min_v),
    .max_i_stretch    (max_v),
    .rd_en_o_stretch  (rd_en),
    .rd_addr_o_stretch(rd_addr),
    .rd_data_i_stretch(rd_data),
    .wr_en_o_stretch  (wr_en),
    .wr_addr_o_stretch(wr_addr),
    .wr_data_o_stretch(wr_data),
    .last_o_stretch   (last),
    .busy_o_stretch   (busy),
    .done_o_stretch   (done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem  [D];
  logic [DW-1:0] expv [D];

  always @(posedge clk)
    if (rd_en) rd_data <= mem[rd_addr];

  // index of the next rising edge, as seen from the falling edge
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  int start_idx;
  int first_rd, done_rel, nwr, nlast, ndone, last_addr;
  int wdat [D];
  int wcyc [D];
  int rcyc [D];

  always @(negedge clk) begin
    automatic int rel = cyc - start_idx;
    if (rd_en) begin
      if (first_rd < 0) first_rd = rel;
      rcyc[rd_addr] = rel;
    end
    if (wr_en) begin
      nwr++;
      wdat[wr_addr] = int'(wr_data);
      wcyc[wr_addr] = rel;
      if (last) begin
        nlast++;
        last_addr = int'(wr_addr);
      end
    end
    if (done) begin
      ndone++;
      done_rel = rel;
    end
  end

  task automatic clear_rec();
    first_rd = -1; done_rel = -1; last_addr = -1;
    nwr = 0; nlast = 0; ndone = 0;
    for (int i = 0; i < D; i++) begin
      wdat[i] = -1; wcyc[i] = -1; rcyc[i] = -1;
    end
  endtask

  task automatic pulse_start(input logic [DW-1:0] mn,
                             input logic [DW-1:0] mx);
    @(negedge clk);
    min_v = mn; max_v = mx; start = 1'b1;
    start_idx = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [DW-1:0] mn,
                           input logic [DW-1:0] mx, input bit dup);
    clear_rec();
    pulse_start(mn, mx);
    if (dup) begin
      repeat (20) @(negedge clk);
      min_v = 8'd3; max_v = 8'd9; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int k = 0; k < 200 && ndone == 0; k++) @(negedge clk);
    chk({name, ":done_seen"}, ndone, 1);
    @(posedge clk); #1;
    chk({name, ":busy_after"}, busy, 0);
    chk({name, ":first_rd"}, first_rd, 17);
    chk({name, ":done_cyc"}, done_rel, D + 20);
    chk({name, ":n_writes"}, nwr, D);
    chk({name, ":n_last"}, nlast, 1);
    chk({name, ":last_addr"}, last_addr, D - 1);
    for (int a = 0; a < D; a++) begin
      chk($sformatf("%s:data[%0d]", name, a), wdat[a], expv[a]);
      chk($sformatf("%s:wcyc[%0d]", name, a), wcyc[a], 20 + a);
      chk($sformatf("%s:lag[%0d]", name, a), wcyc[a] - rcyc[a], 3);
    end
  endtask

  logic [DW-1:0] p5 [5] = '{8'd50, 8'd125, 8'd200, 8'd30, 8'd250};
  logic [DW-1:0] e5 [5] = '{8'd0, 8'd127, 8'd255, 8'd0, 8'd255};
  logic [DW-1:0] p3 [3] = '{8'd100, 8'd101, 8'd150};
  logic [DW-1:0] e3 [3] = '{8'd0, 8'd255, 8'd255};

  task automatic load_ramp();
    for (int i = 0; i < D; i++) begin
      mem[i] = DW'(i); expv[i] = DW'(i);
    end
  endtask

  task automatic load_rand();
    for (int i = 0; i < D; i++) begin
      mem[i] = DW'($urandom_range(0, 255)); expv[i] = mem[i];
    end
  endtask

  initial begin
    int saved;
    bit hit;
    start_idx = 0;
    clear_rec();
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outs", {rd_en, rd_addr, wr_en, wr_addr, wr_data,
                       last, busy, done}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    load_ramp();
    run_frame("ramp", 8'd0, 8'd255, 1'b1);

    for (int i = 0; i < D; i++) begin
      mem[i] = p5[i % 5]; expv[i] = e5[i % 5];
    end
    run_frame("mid", 8'd50, 8'd200, 1'b0);

    for (int i = 0; i < D; i++) begin
      mem[i] = p3[i % 3]; expv[i] = e3[i % 3];
    end
    run_frame("narrow", 8'd100, 8'd101, 1'b0);

    load_rand();
    run_frame("byp_eq", 8'd77, 8'd77, 1'b0);
    load_rand();
    run_frame("byp_inv", 8'd90, 8'd40, 1'b0);

    load_ramp();
    clear_rec();
    pulse_start(8'd0, 8'd255);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      hit = rd_en && (rd_addr == AW'(7));
    end
    chk("rst_reach_addr7", hit, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_outs", {rd_en, rd_addr, wr_en, wr_addr, wr_data,
                           last, busy, done}, 0);
    saved = nwr;
    repeat (5) @(negedge clk);
    chk("rst_no_writes", nwr - saved, 0);
    chk("rst_no_done", ndone, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < D; i++) begin
      mem[i] = p5[i % 5]; expv[i] = e5[i % 5];
    end
    run_frame("after_rst", 8'd50, 8'd200, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
